// File: rtl/fifo.sv
// Synchronous single-clock FIFO with registered read data.
// Reads and writes are qualified by the pre-edge empty/full flags, so a same-cycle read never frees room for a write.
module fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             write_en,
    input  logic [WIDTH-1:0] data_in,
    input  logic             read_en,
    output logic [WIDTH-1:0] data_out,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_write;
    logic             do_read;

    assign do_write = write_en && !full;
    assign do_read  = read_en && !empty;

    assign empty = (count == '0);
    assign full  = (count == FULL_COUNT);

    // Storage is deliberately left uncleared on reset; zeroed pointers and count make stale words unreachable.
    always_ff @(posedge clk) begin
        if (!rst && do_write) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            data_out <= '0;
        end else begin
            if (do_write) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_read) begin
                rd_ptr   <= rd_ptr + AW'(1);
                data_out <= mem[rd_ptr];
            end
            case ({do_write, do_read})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo.sv
// Self-checking bench for fifo: a queue of written words predicts every popped value and the empty/full flags.
module tb_fifo;

    localparam int DEPTH = 4;
    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             write_en;
    logic [WIDTH-1:0] data_in;
    logic             read_en;
    logic [WIDTH-1:0] data_out;
    logic             empty;
    logic             full;

    logic [WIDTH-1:0] scoreboard [$];
    logic [WIDTH-1:0] expData;
    int               errors;
    int               checks;

    fifo #(DEPTH, WIDTH) dut (
        .clk      (clk),
        .rst      (rst),
        .write_en (write_en),
        .data_in  (data_in),
        .read_en  (read_en),
        .data_out (data_out),
        .empty    (empty),
        .full     (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic checkState(input string tag);
        checkOutput({tag, ".data_out"}, 32'(data_out), 32'(expData));
        checkOutput({tag, ".empty"}, 32'(empty), 32'(scoreboard.size() == 0));
        checkOutput({tag, ".full"}, 32'(full), 32'(scoreboard.size() == DEPTH));
    endtask

    // One clock edge with the given requests; the model decides acceptance from its pre-edge occupancy.
    task automatic applyStimulus(input string tag, input logic we, input logic [WIDTH-1:0] din, input logic re);
        bit accW;
        bit accR;
        write_en = we;
        data_in  = din;
        read_en  = re;
        accW = we && (scoreboard.size() < DEPTH);
        accR = re && (scoreboard.size() > 0);
        @(posedge clk);
        if (accR) expData = scoreboard.pop_front();
        if (accW) scoreboard.push_back(din);
        #1;
        write_en = 1'b0;
        read_en  = 1'b0;
        checkState(tag);
    endtask

    // Requests are held high during reset to show they are ignored.
    task automatic doReset(input string tag);
        rst      = 1'b1;
        write_en = 1'b1;
        read_en  = 1'b1;
        data_in  = 8'hA5;
        @(posedge clk);
        scoreboard.delete();
        expData = '0;
        #1;
        rst      = 1'b0;
        write_en = 1'b0;
        read_en  = 1'b0;
        checkState(tag);
    endtask

    initial begin
        errors   = 0;
        checks   = 0;
        expData  = '0;
        rst      = 1'b1;
        write_en = 1'b0;
        read_en  = 1'b0;
        data_in  = '0;
        @(posedge clk);
        #1;
        doReset("reset");
        checkOutput("reset.data_out_const", 32'(data_out), 32'h00);
        checkOutput("reset.empty_const", 32'(empty), 32'd1);

        applyStimulus("fill0", 1'b1, 8'h24, 1'b0);
        applyStimulus("fill1", 1'b1, 8'h81, 1'b0);
        applyStimulus("fill2", 1'b1, 8'h09, 1'b0);
        applyStimulus("fill3", 1'b1, 8'h63, 1'b0);
        checkOutput("fill.full_const", 32'(full), 32'd1);
        applyStimulus("drop_ff", 1'b1, 8'hFF, 1'b0);

        for (int i = 0; i < 4; i++) applyStimulus($sformatf("drain%0d", i), 1'b0, 8'h00, 1'b1);
        checkOutput("drain.last_const", 32'(data_out), 32'h63);
        applyStimulus("read_empty", 1'b0, 8'h00, 1'b1);
        checkOutput("read_empty.hold_const", 32'(data_out), 32'h63);

        applyStimulus("wrapW0", 1'b1, 8'h11, 1'b0);
        applyStimulus("wrapW1", 1'b1, 8'h22, 1'b0);
        applyStimulus("wrapW2", 1'b1, 8'h33, 1'b0);
        applyStimulus("wrapR0", 1'b0, 8'h00, 1'b1);
        applyStimulus("wrapR1", 1'b0, 8'h00, 1'b1);
        applyStimulus("wrapW3", 1'b1, 8'h44, 1'b0);
        applyStimulus("wrapW4", 1'b1, 8'h55, 1'b0);
        applyStimulus("wrapW5", 1'b1, 8'h66, 1'b0);
        checkOutput("wrap.full_const", 32'(full), 32'd1);
        for (int i = 0; i < 4; i++) applyStimulus($sformatf("wrapR%0d", i + 2), 1'b0, 8'h00, 1'b1);

        applyStimulus("two0", 1'b1, 8'hA1, 1'b0);
        applyStimulus("two1", 1'b1, 8'hA2, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus($sformatf("both%0d", i), 1'b1, 8'(8'hB0 + i), 1'b1);
        applyStimulus("bothDrain0", 1'b0, 8'h00, 1'b1);
        applyStimulus("bothDrain1", 1'b0, 8'h00, 1'b1);
        checkOutput("both.order_const", 32'(data_out), 32'hB2);

        applyStimulus("bothEmpty", 1'b1, 8'hC0, 1'b1);
        checkOutput("bothEmpty.empty_const", 32'(empty), 32'd0);
        applyStimulus("refill0", 1'b1, 8'hC1, 1'b0);
        applyStimulus("refill1", 1'b1, 8'hC2, 1'b0);
        applyStimulus("refill2", 1'b1, 8'hC3, 1'b0);
        applyStimulus("bothFull", 1'b1, 8'hDD, 1'b1);
        checkOutput("bothFull.data_const", 32'(data_out), 32'hC0);
        checkOutput("bothFull.full_const", 32'(full), 32'd0);

        doReset("midReset");
        checkOutput("midReset.data_const", 32'(data_out), 32'h00);
        applyStimulus("readAfterReset", 1'b0, 8'h00, 1'b1);

        for (int i = 0; i < 400; i++) begin
            if (i % 97 == 96) doReset($sformatf("rndReset%0d", i));
            else applyStimulus($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
